// File: rtl/dmiss_handler.sv
// Miss engine for the dual-issue D-cache. It picks one of two held slot misses (slot 1 wins) and runs a block refill or a sized store on the bus, one at a time.
// done comes 1 + grant wait + B beats + 1 cycles after IDLE for reads, and 3 + waits for writes; a slow bus_gnt/rvalid/wack only stretches the state it stalls.
module dmiss_handler #(
  parameter int B = 8,
  parameter int b = 3,
  parameter int y = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         miss1,
  input  logic [63:0]  addr1,
  input  logic         write1,
  input  logic [2:0]   size1,
  input  logic [63:0]  wdata1,
  input  logic         miss2,
  input  logic [63:0]  addr2,
  input  logic         write2,
  input  logic [2:0]   size2,
  input  logic [63:0]  wdata2,
  output logic         done1,
  output logic         done2,
  output logic         refill_valid,
  output logic         refill_port,
  output logic [b-1:0] refill_idx,
  output logic [63:0]  refill_data,
  output logic         refill_last,
  output logic         bus_req,
  output logic [63:0]  bus_addr,
  output logic         bus_we,
  output logic [2:0]   bus_size,
  output logic [63:0]  bus_wdata,
  input  logic         bus_gnt,
  input  logic         bus_rvalid,
  input  logic [63:0]  bus_rdata,
  input  logic         bus_wack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [63:0]  ALIGN_MASK = ~((64'd1 << (b + y)) - 64'd1);
  localparam logic [b-1:0] LAST_IDX   = b'(B - 1);

  state_t       r_state;
  state_t       w_next;

  logic [63:0]  r_addr;
  logic         r_we;
  logic [2:0]   r_size;
  logic [63:0]  r_wdata;
  logic         r_port;
  logic [b-1:0] r_cnt;

  logic         r_done1;
  logic         r_done2;
  logic         r_refill_valid;
  logic         r_refill_port;
  logic [b-1:0] r_refill_idx;
  logic [63:0]  r_refill_data;
  logic         r_refill_last;
  logic         r_bus_req;
  logic [63:0]  r_bus_addr;
  logic         r_bus_we;
  logic [2:0]   r_bus_size;
  logic [63:0]  r_bus_wdata;

  logic         w_take;
  logic         w_sel2;
  logic [63:0]  w_addr;
  logic         w_we;
  logic [2:0]   w_size;
  logic [63:0]  w_wdata;
  logic         w_beat;
  logic         w_last_beat;

  // Slot 1 is older in program order, so it wins whenever both are pending.
  assign w_take      = (r_state == S_IDLE) && (miss1 || miss2);
  assign w_sel2      = !miss1;
  assign w_addr      = w_sel2 ? addr2  : addr1;
  assign w_we        = w_sel2 ? write2 : write1;
  assign w_size      = w_sel2 ? size2  : size1;
  assign w_wdata     = w_sel2 ? wdata2 : wdata1;
  assign w_beat      = (r_state == S_RD) && bus_rvalid;
  assign w_last_beat = w_beat && (r_cnt == LAST_IDX);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (miss1 || miss2) w_next = S_REQ;
      S_REQ:  if (bus_gnt)        w_next = r_we ? S_WR : S_RD;
      S_RD:   if (w_last_beat)    w_next = S_DONE;
      S_WR:   if (bus_wack)       w_next = S_DONE;
      S_DONE:                     w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_we           <= 1'b0;
      r_size         <= '0;
      r_wdata        <= '0;
      r_port         <= 1'b0;
      r_cnt          <= '0;
      r_done1        <= 1'b0;
      r_done2        <= 1'b0;
      r_refill_valid <= 1'b0;
      r_refill_port  <= 1'b0;
      r_refill_idx   <= '0;
      r_refill_data  <= '0;
      r_refill_last  <= 1'b0;
      r_bus_req      <= 1'b0;
      r_bus_addr     <= '0;
      r_bus_we       <= 1'b0;
      r_bus_size     <= '0;
      r_bus_wdata    <= '0;
    end else begin
      r_state <= w_next;

      // The bus fields are loaded together with the latch, so they are stable for the whole REQ phase.
      if (w_take) begin
        r_addr      <= w_addr;
        r_we        <= w_we;
        r_size      <= w_size;
        r_wdata     <= w_wdata;
        r_port      <= w_sel2;
        r_cnt       <= '0;
        r_bus_req   <= 1'b1;
        r_bus_addr  <= w_we ? w_addr : (w_addr & ALIGN_MASK);
        r_bus_we    <= w_we;
        r_bus_size  <= w_we ? w_size  : 3'd0;
        r_bus_wdata <= w_we ? w_wdata : 64'd0;
      end else if ((r_state == S_REQ) && bus_gnt) begin
        r_bus_req <= 1'b0;
      end

      r_refill_valid <= w_beat;
      r_refill_last  <= w_last_beat;
      if (w_beat) begin
        r_refill_data <= bus_rdata;
        r_refill_idx  <= r_cnt;
        r_refill_port <= r_port;
        r_cnt         <= r_cnt + 1'b1;
      end

      r_done1 <= (w_next == S_DONE) && !r_port;
      r_done2 <= (w_next == S_DONE) &&  r_port;
    end
  end

  assign done1        = r_done1;
  assign done2        = r_done2;
  assign refill_valid = r_refill_valid;
  assign refill_port  = r_refill_port;
  assign refill_idx   = r_refill_idx;
  assign refill_data  = r_refill_data;
  assign refill_last  = r_refill_last;
  assign bus_req      = r_bus_req;
  assign bus_addr     = r_bus_addr;
  assign bus_we       = r_bus_we;
  assign bus_size     = r_bus_size;
  assign bus_wdata    = r_bus_wdata;

endmodule

// File: tb/tb_dmiss_handler.sv
// Bench for dmiss_handler: a scripted bus and cache drive randomized misses, and the
// observed refills, bus phases and done cycles are checked against timing computed from the plan.
module tb_dmiss_handler;

  localparam int NB = 8;

  logic        clk;
  logic        reset_n;
  logic        miss1, write1, miss2, write2;
  logic [63:0] addr1, wdata1, addr2, wdata2;
  logic [2:0]  size1, size2;
  logic        done1, done2;
  logic        refill_valid, refill_port, refill_last;
  logic [2:0]  refill_idx;
  logic [63:0] refill_data;
  logic        bus_req, bus_we;
  logic [63:0] bus_addr, bus_wdata;
  logic [2:0]  bus_size;
  logic        bus_gnt, bus_rvalid, bus_wack;
  logic [63:0] bus_rdata;

  dmiss_handler #(.B(8), .b(3), .y(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .miss1(miss1), .addr1(addr1), .write1(write1), .size1(size1), .wdata1(wdata1),
    .miss2(miss2), .addr2(addr2), .write2(write2), .size2(size2), .wdata2(wdata2),
    .done1(done1), .done2(done2),
    .refill_valid(refill_valid), .refill_port(refill_port), .refill_idx(refill_idx),
    .refill_data(refill_data), .refill_last(refill_last),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_we(bus_we), .bus_size(bus_size),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_wack(bus_wack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [2:0]  idx;
    logic [63:0] data;
    logic        last;
    logic        port;
  } rw_t;

  int          checks = 0;
  int          errors = 0;

  rw_t         rq[$];
  int          d1_cyc[$];
  int          d2_cyc[$];
  logic [63:0] seen_addr[$];
  logic        seen_we[$];
  logic [2:0]  seen_size[$];
  logic [63:0] seen_wdata[$];
  int          req_n;
  bit          req_unstable;

  logic [63:0] beat[NB];
  int          gap[NB];
  int          gnt_wait;
  int          wack_wait;

  // Plays both the bus and the cache for one run; cycle 0 is the IDLE cycle that sees the miss.
  task automatic serve(input int n_done, input int stop_words, input int drop_words, output bit ok);
    int c = 0, ph = 0, cnt = 0, k = 0, extra = 3;
    ok = 1'b1;
    rq.delete(); d1_cyc.delete(); d2_cyc.delete();
    seen_addr.delete(); seen_we.delete(); seen_size.delete(); seen_wdata.delete();
    req_n = 0; req_unstable = 1'b0;
    while (1) begin
      if (refill_valid) rq.push_back('{c, refill_idx, refill_data, refill_last, refill_port});
      if (done1) begin d1_cyc.push_back(c); miss1 = 1'b0; end
      if (done2) begin d2_cyc.push_back(c); miss2 = 1'b0; end
      if (stop_words > 0 && rq.size() == stop_words) break;
      if (drop_words > 0 && rq.size() == drop_words) miss1 = 1'b0;
      if (d1_cyc.size() + d2_cyc.size() >= n_done) begin
        if (extra == 0) break;
        extra--;
      end
      if (c >= 300) begin ok = 1'b0; break; end
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_wack = 1'b0;
      bus_rdata = {$urandom, $urandom};
      if (bus_req) begin
        if (ph != 1) begin
          ph = 1; cnt = 0;
          seen_addr.push_back(bus_addr); seen_we.push_back(bus_we);
          seen_size.push_back(bus_size); seen_wdata.push_back(bus_wdata);
        end else if (bus_addr !== seen_addr[$] || bus_we !== seen_we[$] ||
                     bus_size !== seen_size[$] || bus_wdata !== seen_wdata[$]) begin
          req_unstable = 1'b1;
        end
        req_n++;
        if (cnt == gnt_wait) begin
          bus_gnt = 1'b1; ph = bus_we ? 3 : 2; cnt = 0; k = 0;
        end else cnt++;
      end else if (ph == 2) begin
        if (cnt == gap[k]) begin
          bus_rvalid = 1'b1; bus_rdata = beat[k]; k++; cnt = 0;
          if (k == NB) ph = 0;
        end else cnt++;
      end else if (ph == 3) begin
        if (cnt == wack_wait) begin bus_wack = 1'b1; ph = 0; end
        else cnt++;
      end
      c++;
      @(negedge clk);
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_wack = 1'b0;
  endtask

  task automatic plan_read(input int max_gap);
    for (int k = 0; k < NB; k++) begin
      beat[k] = {$urandom, $urandom};
      gap[k]  = (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
    end
  endtask

  // The cycle on which refill word k should be visible, from the bus plan alone.
  function automatic int refill_cycle(input int k);
    int s = 0;
    for (int j = 0; j <= k; j++) s += gap[j];
    return 2 + gnt_wait + s + k + 1;
  endfunction

  task automatic check_refill(input string nm, input logic port);
    checks++;
    if (rq.size() != NB) begin
      errors++; $display("FAIL %s_count got %0d want %0d", nm, rq.size(), NB);
    end
    for (int k = 0; k < rq.size() && k < NB; k++) begin
      checks++;
      if (rq[k].idx !== 3'(k) || rq[k].data !== beat[k] || rq[k].last !== (k == NB - 1) ||
          rq[k].port !== port || rq[k].cyc != refill_cycle(k)) begin
        errors++;
        $display("FAIL %s_word%0d got idx=%0d data=%h last=%b port=%b cyc=%0d want idx=%0d data=%h last=%b port=%b cyc=%0d",
                 nm, k, rq[k].idx, rq[k].data, rq[k].last, rq[k].port, rq[k].cyc,
                 k, beat[k], (k == NB - 1), port, refill_cycle(k));
      end
    end
  endtask

  task automatic test_reset;
    logic [207:0] outs;
    outs = {done1, done2, refill_valid, refill_port, refill_idx, refill_data, refill_last,
            bus_req, bus_addr, bus_we, bus_size, bus_wdata};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs); end
  endtask

  task automatic test_read_basic;
    bit ok;
    for (int k = 0; k < NB; k++) begin beat[k] = 64'hA0 + 64'(k); gap[k] = 0; end
    gnt_wait = 0; wack_wait = 0;
    addr1 = 64'h1234; write1 = 1'b0; miss1 = 1'b1;
    serve(1, 0, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL read_basic_timeout got stuck want done"); end
    checks++;
    if (seen_addr.size() != 1 || seen_addr[0] !== 64'h1200 || seen_we[0] !== 1'b0) begin
      errors++; $display("FAIL read_basic_bus got n=%0d addr=%h want n=1 addr=1200 we=0", seen_addr.size(), seen_addr[0]);
    end
    check_refill("read_basic", 1'b0);
    checks++;
    if (d1_cyc.size() != 1 || d1_cyc[0] != 10) begin
      errors++; $display("FAIL read_basic_done1 got n=%0d cyc=%0d want n=1 cyc=10", d1_cyc.size(), d1_cyc[0]);
    end
    checks++;
    if (d2_cyc.size() != 0) begin errors++; $display("FAIL read_basic_done2 got %0d pulses want 0", d2_cyc.size()); end
  endtask

  task automatic test_priority;
    bit ok;
    int s, e1, e2;
    for (int it = 0; it < 3; it++) begin
      plan_read(2);
      gnt_wait = int'($urandom_range(0, 2)); wack_wait = int'($urandom_range(0, 2));
      addr1 = {$urandom, $urandom}; write1 = 1'b0; size1 = 3'($urandom);
      addr2 = {$urandom, $urandom}; write2 = 1'b1; size2 = 3'($urandom_range(0, 3));
      wdata2 = {$urandom, $urandom};
      miss1 = 1'b1; miss2 = 1'b1;
      serve(2, 0, 0, ok);
      s = 0; for (int j = 0; j < NB; j++) s += gap[j];
      e1 = 2 + gnt_wait + s + NB;
      e2 = e1 + 1 + 3 + gnt_wait + wack_wait;
      checks++; if (!ok) begin errors++; $display("FAIL prio_timeout it=%0d", it); end
      checks++;
      if (seen_addr.size() != 2) begin
        errors++; $display("FAIL prio_txn_count got %0d want 2", seen_addr.size());
      end else begin
        checks++;
        if (seen_addr[0] !== {addr1[63:6], 6'd0} || seen_we[0] !== 1'b0) begin
          errors++; $display("FAIL prio_first got addr=%h we=%b want addr=%h we=0", seen_addr[0], seen_we[0], {addr1[63:6], 6'd0});
        end
        checks++;
        if (seen_addr[1] !== addr2 || seen_we[1] !== 1'b1 || seen_size[1] !== size2 || seen_wdata[1] !== wdata2) begin
          errors++; $display("FAIL prio_second got addr=%h we=%b size=%0d wd=%h want addr=%h we=1 size=%0d wd=%h",
                             seen_addr[1], seen_we[1], seen_size[1], seen_wdata[1], addr2, size2, wdata2);
        end
      end
      check_refill("prio", 1'b0);
      checks++;
      if (d1_cyc.size() != 1 || d2_cyc.size() != 1 || d1_cyc[0] != e1 || d2_cyc[0] != e2) begin
        errors++; $display("FAIL prio_done got d1=%0d d2=%0d want d1=%0d d2=%0d", d1_cyc[0], d2_cyc[0], e1, e2);
      end
    end
  endtask

  task automatic test_write_delayed;
    bit ok;
    gnt_wait = 3; wack_wait = 2;
    addr2 = 64'h1003; size2 = 3'd0; wdata2 = 64'h5A; write2 = 1'b1; miss2 = 1'b1;
    serve(1, 0, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_timeout got stuck want done"); end
    checks++;
    if (req_n != 4 || req_unstable) begin
      errors++; $display("FAIL wr_req_hold got cycles=%0d unstable=%b want cycles=4 unstable=0", req_n, req_unstable);
    end
    checks++;
    if (seen_addr.size() != 1 || seen_addr[0] !== 64'h1003 || seen_wdata[0] !== 64'h5A || seen_size[0] !== 3'd0 || seen_we[0] !== 1'b1) begin
      errors++; $display("FAIL wr_bus got addr=%h wd=%h want addr=1003 wd=5a", seen_addr[0], seen_wdata[0]);
    end
    checks++;
    if (d2_cyc.size() != 1 || d2_cyc[0] != 8 || d1_cyc.size() != 0 || rq.size() != 0) begin
      errors++; $display("FAIL wr_done got d2=%0d cyc=%0d d1=%0d refills=%0d want 1 at 8, 0, 0",
                         d2_cyc.size(), d2_cyc[0], d1_cyc.size(), rq.size());
    end
  endtask

  task automatic test_gaps;
    bit ok;
    logic port;
    int s;
    for (int it = 0; it < 5; it++) begin
      plan_read(3);
      if (it == 0) for (int k = 0; k < NB; k++) gap[k] = (k == 0) ? 0 : 2;
      gnt_wait = int'($urandom_range(0, 3));
      port = (it == 0) ? 1'b0 : 1'($urandom);
      if (port) begin addr2 = {$urandom, $urandom}; write2 = 1'b0; miss2 = 1'b1; end
      else      begin addr1 = {$urandom, $urandom}; write1 = 1'b0; miss1 = 1'b1; end
      serve(1, 0, 0, ok);
      s = 0; for (int j = 0; j < NB; j++) s += gap[j];
      checks++; if (!ok) begin errors++; $display("FAIL gaps_timeout it=%0d", it); end
      check_refill("gaps", port);
      checks++;
      if ((port ? d2_cyc.size() : d1_cyc.size()) != 1 || (port ? d2_cyc[0] : d1_cyc[0]) != 2 + gnt_wait + s + NB) begin
        errors++; $display("FAIL gaps_done it=%0d got cyc=%0d want %0d", it, port ? d2_cyc[0] : d1_cyc[0], 2 + gnt_wait + s + NB);
      end
    end
  endtask

  task automatic test_spurious;
    bit bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus_rvalid = 1'($urandom); bus_wack = 1'($urandom); bus_gnt = 1'($urandom);
      bus_rdata = {$urandom, $urandom};
      @(negedge clk);
      if (refill_valid || done1 || done2 || bus_req) bad = 1'b1;
    end
    bus_rvalid = 1'b0; bus_wack = 1'b0; bus_gnt = 1'b0;
    checks++;
    if (bad) begin errors++; $display("FAIL spurious_idle got activity want none"); end
  endtask

  task automatic test_reset_mid;
    bit ok, bad;
    logic [207:0] outs;
    plan_read(0); gnt_wait = 0;
    addr1 = {$urandom, $urandom}; write1 = 1'b0; miss1 = 1'b1;
    serve(1, 4, 0, ok);
    checks++;
    if (rq.size() != 4 || rq[3].idx !== 3'd3) begin
      errors++; $display("FAIL rstmid_pre got words=%0d want 4", rq.size());
    end
    reset_n = 1'b0;
    #1;
    outs = {done1, done2, refill_valid, refill_port, refill_idx, refill_data, refill_last,
            bus_req, bus_addr, bus_we, bus_size, bus_wdata};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL rstmid_outputs got %h want 0", outs); end
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done1 || done2 || refill_valid) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL rstmid_quiet got activity in reset want none"); end
    reset_n = 1'b1;
    plan_read(1);
    serve(1, 0, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout got stuck want done"); end
    check_refill("rstmid", 1'b0);
    checks++;
    if (d1_cyc.size() != 1) begin errors++; $display("FAIL rstmid_done got %0d pulses want 1", d1_cyc.size()); end
  endtask

  task automatic test_drop_in_rd;
    bit ok;
    plan_read(1); gnt_wait = 1;
    addr1 = {$urandom, $urandom}; write1 = 1'b0; miss1 = 1'b1;
    serve(1, 0, 2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL drop_timeout got stuck want done"); end
    check_refill("drop", 1'b0);
    checks++;
    if (d1_cyc.size() != 1 || seen_addr.size() != 1 || req_n != 2) begin
      errors++; $display("FAIL drop_after got done=%0d txns=%0d req=%0d want 1 1 2", d1_cyc.size(), seen_addr.size(), req_n);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    miss1 = 1'b0; addr1 = '0; write1 = 1'b0; size1 = '0; wdata1 = '0;
    miss2 = 1'b0; addr2 = '0; write2 = 1'b0; size2 = '0; wdata2 = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_wack = 1'b0;
    gnt_wait = 0; wack_wait = 0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    @(negedge clk);
    test_read_basic();
    test_spurious();
    test_priority();
    test_write_delayed();
    test_gaps();
    test_reset_mid();
    test_drop_in_rd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
